stream_mux_rr: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshake on every channel.
- Successor to the combinational word-select muxes. It adds a fixed-select mode (software/FSM-driven sel) and a round-robin arbitration mode.
- Sits between multiple producers (memory read port, ALU result, immediate path, debug port) and a single consumer stage of the multicycle datapath.
- Output is registered: one-cycle latency, one transfer per cycle at full throughput.

---
 rtl/stream_mux_rr.sv | 130 +++++++++++++
 tb/tb_stream_mux_rr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream mux, fixed-select or round-robin
// One output register; a channel is accepted whenever that register is free or draining.
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready
);

  generate
    if ((1 << SEL_W) < N || N < 2 || N > 32 || WIDTH < 1) begin : g_param_check
      $error("stream_mux_rr: illegal WIDTH/N/SEL_W combination");
    end
  endgenerate

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_chan_q, out_chan_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic               can_load;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;
  logic [WIDTH-1:0]   grant_data;
  logic               hi_found, lo_found;
  logic [SEL_W-1:0]   hi_idx, lo_idx;

  assign can_load = !out_valid_q || out_ready;

  // Round-robin: lowest valid channel at or above ptr wins, else lowest valid overall (wrap).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_found  = 1'b0;
    lo_idx    = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          lo_found = 1'b1;
          lo_idx   = SEL_W'(i);
          if (SEL_W'(i) >= ptr_q) begin
            hi_found = 1'b1;
            hi_idx   = SEL_W'(i);
          end
        end
      end
      if (hi_found) begin
        grant_vld = 1'b1;
        grant_idx = hi_idx;
      end else if (lo_found) begin
        grant_vld = 1'b1;
        grant_idx = lo_idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && can_load && grant_vld) begin
      for (int i = 0; i < N; i++) begin
        in_ready[i] = (grant_idx == SEL_W'(i));
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (can_load && grant_vld) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      if (mode) begin
        ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed bench with a per-cycle reference model for stream_mux_rr
// Model state is the spec's own view: one held word plus a rotating start index.
module tb_stream_mux_rr;

  localparam int NCH = 4;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic [1:0]    sel;
  logic [3:0]    in_valid;
  logic [127:0]  in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [1:0]    out_chan;
  logic          out_ready;

  logic          mode3;
  logic [1:0]    sel3;
  logic [2:0]    in_valid3;
  logic [95:0]   in_data3;
  logic [2:0]    in_ready3;
  logic          out_valid3;
  logic [31:0]   out_data3;
  logic [1:0]    out_chan3;
  logic          out_ready3;

  int checks   = 0;
  int failures = 0;

  stream_mux_rr #(.WIDTH(32), .N(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(32), .N(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_chan(out_chan3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: held output word and round-robin start channel.
  bit          m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_chan  = 0;
  int          m_ptr   = 0;

  function automatic void model_grant(output bit found, output int g);
    found = 1'b0;
    g     = 0;
    if (!mode) begin
      if (int'(sel) < NCH && in_valid[sel]) begin
        found = 1'b1;
        g     = int'(sel);
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (!found && in_valid[c]) begin
          found = 1'b1;
          g     = c;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit found;
    int g;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = 0;
    end else begin
      model_grant(found, g);
      if ((!m_valid || out_ready) && found) begin
        m_valid = 1'b1;
        m_data  = in_data[g*32 +: 32];
        m_chan  = g;
        if (mode) m_ptr = (g + 1) % NCH;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit         found;
    int         g;
    logic [3:0] exp_ir;
    model_grant(found, g);
    exp_ir = '0;
    if (rst_n && (!m_valid || out_ready) && found) exp_ir[g] = 1'b1;
    checks++;
    if (in_ready !== exp_ir) begin
      failures++;
      $display("FAIL model_in_ready t=%0t got=%b want=%b", $time, in_ready, exp_ir);
    end
    checks++;
    if (out_valid !== m_valid) begin
      failures++;
      $display("FAIL model_out_valid t=%0t got=%b want=%b", $time, out_valid, m_valid);
    end
    if (m_valid) begin
      checks++;
      if (out_data !== m_data || out_chan !== 2'(m_chan)) begin
        failures++;
        $display("FAIL model_out_word t=%0t got=%h/%0d want=%h/%0d",
                 $time, out_data, out_chan, m_data, m_chan);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_1111;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'hC3C3_3333;

  initial begin
    int rr_seq [6];
    int sp_seq [4];
    rr_seq = '{0, 1, 2, 3, 0, 1};
    sp_seq = '{3, 0, 3, 0};

    rst_n      = 1'b0;
    mode       = 1'b1;
    sel        = 2'd0;
    in_valid   = 4'b1111;
    in_data    = {D3, D2, D1, D0};
    out_ready  = 1'b1;
    mode3      = 1'b0;
    sel3       = 2'd0;
    in_valid3  = 3'b000;
    in_data3   = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    out_ready3 = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    #2 rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'b0001);

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_out_valid", 32'(out_valid), 32'd1);
      chk("rr_out_chan", 32'(out_chan), 32'(rr_seq[k]));
    end

    #2 in_valid = 4'b0001;
    @(negedge clk);
    chk("rr_solo_chan", 32'(out_chan), 32'd0);
    #2 in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("sparse_out_chan", 32'(out_chan), 32'(sp_seq[k]));
    end

    #2 begin mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fixed_in_ready", 32'(in_ready), 32'b0100);
      chk("fixed_out_data", out_data, D2);
      chk("fixed_out_valid", 32'(out_valid), 32'd1);
    end

    #2 begin mode = 1'b1; out_ready = 1'b0; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_data", out_data, D2);
      chk("bp_out_chan", 32'(out_chan), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    #2 out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'b0010);
    @(negedge clk);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_data", out_data, D1);
    #2 in_valid = 4'b0000;
    @(negedge clk);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    #2 in_valid = 4'b1111;
    @(negedge clk);
    chk("pre_reset_chan", 32'(out_chan), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rerelease_in_ready", 32'(in_ready), 32'b0001);
    @(negedge clk);
    chk("rerelease_chan", 32'(out_chan), 32'd0);

    #2 begin in_valid3 = 3'b111; sel3 = 2'd0; out_ready3 = 1'b0; end
    @(negedge clk);
    chk("n3_load_valid", 32'(out_valid3), 32'd1);
    chk("n3_load_data", out_data3, 32'h3333_0000);
    #2 sel3 = 2'd3;
    #1 chk("n3_oor_stall_ready", 32'(in_ready3), 32'd0);
    @(negedge clk);
    chk("n3_hold_valid", 32'(out_valid3), 32'd1);
    #2 out_ready3 = 1'b1;
    #1 chk("n3_oor_free_ready", 32'(in_ready3), 32'd0);
    @(negedge clk);
    chk("n3_drain_valid", 32'(out_valid3), 32'd0);
    chk("n3_drain_ready", 32'(in_ready3), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
